// File: rtl/flag_context_ctrl_pkg.sv
// Shared definitions for the flag context controller and the branch unit.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package flag_context_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    // Bit positions inside a {C,N,Z,V} flag vector
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    // flagCond codes evaluated by the branch unit
    localparam logic [3:0] COND_AL = 4'd0;  // always
    localparam logic [3:0] COND_EQ = 4'd1;  // Z set
    localparam logic [3:0] COND_NE = 4'd2;  // Z clear
    localparam logic [3:0] COND_CS = 4'd3;  // C set
    localparam logic [3:0] COND_CC = 4'd4;  // C clear
    localparam logic [3:0] COND_MI = 4'd5;  // N set
    localparam logic [3:0] COND_PL = 4'd6;  // N clear
    localparam logic [3:0] COND_VS = 4'd7;  // V set
    localparam logic [3:0] COND_VC = 4'd8;  // V clear

    // Evaluate a branch condition against a flag vector
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] flags);
        logic res;
        res = 1'b0;
        case (cond)
            COND_AL: res = 1'b1;
            COND_EQ: res = flags[FLAG_Z];
            COND_NE: res = ~flags[FLAG_Z];
            COND_CS: res = flags[FLAG_C];
            COND_CC: res = ~flags[FLAG_C];
            COND_MI: res = flags[FLAG_N];
            COND_PL: res = ~flags[FLAG_N];
            COND_VS: res = flags[FLAG_V];
            COND_VC: res = ~flags[FLAG_V];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_context_ctrl_lifo.sv
// DEPTH x 4 LIFO of flag snapshots with occupancy count and full/empty.
// Latency: push/pop take effect on the clock edge; top-of-stack read is combinational.
// Backpressure: push when full and pop when empty are ignored; the caller flags the error.
module flag_lifo
    import flag_context_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [3:0]       push_dat,
    output logic [3:0]       pop_dat,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);

    logic [3:0]     mem [DEPTH];
    logic [PTR_W:0] top;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign top     = count - ONE;
    assign pop_dat = mem[top[PTR_W-1:0]];

    // Storage and occupancy; push wins if both are requested
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            count <= '0;
        end else if (push && !full) begin
            mem[count[PTR_W-1:0]] <= push_dat;
            count <= count + ONE;
        end else if (pop && !empty) begin
            count <= top;
        end
    end

endmodule

// File: rtl/flag_context_ctrl.sv
// Saves/restores {C,N,Z,V} across interrupt entry/return and arbitrates the flag register load port.
// Latency: entry acked 1 cycle after request; restored flags land 2 edges after the return request.
// Backpressure: ALU flag writes are refused (alu_stall) during SAVE/RESTORE and must be retried.
module flag_context_ctrl
    import flag_context_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_flag_we,
    input  logic [3:0]       flags_cur,
    input  logic             enter_req,
    input  logic             ret_req,
    input  logic             err_clr,
    output logic             enter_ack,
    output logic             ret_ack,
    output logic             flag_ld,
    output logic             flag_rest,
    output logic [3:0]       flags_bk,
    output logic             alu_stall,
    output logic [PTR_W:0]   depth,
    output logic             ovf_err,
    output logic             unf_err
);

    state_t         state;
    state_t         state_nxt;
    logic           go_restore;
    logic           push;
    logic           lifo_full;
    logic           lifo_empty;
    logic [3:0]     lifo_top;
    logic [PTR_W:0] lifo_count;
    logic           rest_ok;
    logic           ovf_set;
    logic           unf_set;

    // Enter has priority; a return is only taken from IDLE when no entry is pending
    assign go_restore = (state == ST_IDLE) && !enter_req && ret_req;
    assign push       = (state == ST_SAVE);
    assign ovf_set    = (state == ST_SAVE) && lifo_full;
    assign unf_set    = go_restore && lifo_empty;
    assign depth      = lifo_count;

    flag_lifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_lifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (go_restore),
        .push_dat (flags_cur),
        .pop_dat  (lifo_top),
        .count    (lifo_count),
        .full     (lifo_full),
        .empty    (lifo_empty)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, load-port arbitration and acks
    always_comb begin
        state_nxt = state;
        flag_ld   = 1'b0;
        flag_rest = 1'b0;
        alu_stall = 1'b0;
        enter_ack = 1'b0;
        ret_ack   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gate with reset so no load leaks out while reset is held
                flag_ld = alu_flag_we & rst;
                if (enter_req) begin
                    state_nxt = ST_SAVE;
                end else if (ret_req) begin
                    state_nxt = ST_RESTORE;
                end
            end
            ST_SAVE: begin
                alu_stall = alu_flag_we;
                enter_ack = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_RESTORE: begin
                alu_stall = alu_flag_we;
                flag_rest = rest_ok;
                ret_ack   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pop into the backup port on the IDLE->RESTORE edge; hold it otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_bk <= '0;
            rest_ok  <= 1'b0;
        end else if (go_restore) begin
            rest_ok <= !lifo_empty;
            if (!lifo_empty) begin
                flags_bk <= lifo_top;
            end
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_set | (ovf_err & ~err_clr);
            unf_err <= unf_set | (unf_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_flag_context_ctrl.sv
// Scoreboarded bench: drivers push expected acks, a negedge monitor pops and compares.
// Latency: n/a.
// Backpressure: n/a.
module tb_flag_context_ctrl;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           alu_flag_we = 1'b0;
    logic [3:0]     flags_cur;
    logic           enter_req = 1'b0;
    logic           ret_req = 1'b0;
    logic           err_clr = 1'b0;
    logic           enter_ack, ret_ack, flag_ld, flag_rest, alu_stall, ovf_err, unf_err;
    logic [3:0]     flags_bk;
    logic [PTR_W:0] depth;

    logic [3:0]     alu_val = 4'h0;
    logic [3:0]     freg;

    flag_context_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_flag_we (alu_flag_we),
        .flags_cur   (flags_cur),
        .enter_req   (enter_req),
        .ret_req     (ret_req),
        .err_clr     (err_clr),
        .enter_ack   (enter_ack),
        .ret_ack     (ret_ack),
        .flag_ld     (flag_ld),
        .flag_rest   (flag_rest),
        .flags_bk    (flags_bk),
        .alu_stall   (alu_stall),
        .depth       (depth),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    // Flag register the controller steers: restore beats ALU load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           freg <= 4'h0;
        else if (flag_rest) freg <= flags_bk;
        else if (flag_ld)   freg <= alu_val;
    end
    assign flags_cur = freg;

    typedef struct {
        bit         is_ret;
        bit         rest;
        logic [3:0] bk;
        int         dep;
        bit         err;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: stack of snapshots, architectural flags, sticky errors
    logic [3:0] stk[$];
    logic [3:0] arch    = 4'h0;
    logic [3:0] last_bk = 4'h0;
    bit         m_ovf   = 1'b0;
    bit         m_unf   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard whenever an ack appears
    exp_t mon_e;
    exp_t pend;
    bit   pend_vld = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            pend_vld = 1'b0;
        end else begin
            if (pend_vld) begin
                chk("save_depth", 32'(depth), 32'(pend.dep));
                chk("save_ovf", 32'(ovf_err), 32'(pend.err));
                pend_vld = 1'b0;
            end
            chk("ld_rest_excl", 32'(flag_ld & flag_rest), 32'd0);
            if (enter_ack || ret_ack) begin
                chk("busy_stall", 32'(alu_stall), 32'(alu_flag_we));
                chk("busy_no_ld", 32'(flag_ld), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(enter_ack | ret_ack), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_kind", 32'(ret_ack), 32'(mon_e.is_ret));
                    if (!mon_e.is_ret) begin
                        pend     = mon_e;
                        pend_vld = 1'b1;
                    end else begin
                        chk("rest_flag", 32'(flag_rest), 32'(mon_e.rest));
                        if (mon_e.rest) chk("rest_bk", 32'(flags_bk), 32'(mon_e.bk));
                        chk("rest_depth", 32'(depth), 32'(mon_e.dep));
                        chk("rest_unf", 32'(unf_err), 32'(mon_e.err));
                    end
                end
            end else begin
                chk("idle_ld", 32'(flag_ld), 32'(alu_flag_we));
                chk("idle_stall", 32'(alu_stall), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit want_ret);
        bit got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            tick();
            got = want_ret ? ret_ack : enter_ack;
        end
        if (!got) chk(want_ret ? "ret_ack_timeout" : "enter_ack_timeout", 32'd0, 32'd1);
    endtask

    // ALU traffic refused while the controller is busy
    task automatic busy_cycle();
        alu_flag_we = ($urandom_range(0, 3) != 0);
        alu_val     = 4'($urandom);
        tick();
        alu_flag_we = 1'b0;
    endtask

    task automatic model_enter(input bit alu, input logic [3:0] v, input bit clr);
        exp_t e;
        if (alu) arch = v;
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (stk.size() < DEPTH) stk.push_back(arch);
        else m_ovf = 1'b1;
        e.is_ret = 1'b0; e.rest = 1'b0; e.bk = 4'h0;
        e.dep = stk.size(); e.err = m_ovf;
        sb.push_back(e);
    endtask

    task automatic model_ret(input bit alu, input logic [3:0] v, input bit clr);
        exp_t e;
        if (alu) arch = v;
        if (clr) m_ovf = 1'b0;
        e.is_ret = 1'b1; e.bk = 4'h0;
        if (stk.size() == 0) begin
            m_unf  = 1'b1;
            e.rest = 1'b0;
        end else begin
            if (clr) m_unf = 1'b0;
            e.bk    = stk.pop_back();
            arch    = e.bk;
            last_bk = e.bk;
            e.rest  = 1'b1;
        end
        e.dep = stk.size(); e.err = m_unf;
        sb.push_back(e);
    endtask

    task automatic do_enter(input bit alu, input logic [3:0] v, input bit clr);
        model_enter(alu, v, clr);
        enter_req = 1'b1; alu_flag_we = alu; alu_val = v; err_clr = clr;
        wait_ack(1'b0);
        enter_req = 1'b0; err_clr = 1'b0;
        busy_cycle();
    endtask

    task automatic do_ret(input bit alu, input logic [3:0] v, input bit clr);
        model_ret(alu, v, clr);
        ret_req = 1'b1; alu_flag_we = alu; alu_val = v; err_clr = clr;
        wait_ack(1'b1);
        ret_req = 1'b0; err_clr = 1'b0;
        busy_cycle();
    endtask

    // Simultaneous entry and return: entry first, return on the following IDLE
    task automatic do_both();
        model_enter(1'b0, 4'h0, 1'b0);
        model_ret(1'b0, 4'h0, 1'b0);
        enter_req = 1'b1; ret_req = 1'b1;
        wait_ack(1'b0);
        enter_req = 1'b0;
        wait_ack(1'b1);
        ret_req = 1'b0;
        busy_cycle();
    endtask

    task automatic idle_cycle(input bit we, input logic [3:0] v, input bit clr);
        alu_flag_we = we; alu_val = v; err_clr = clr;
        if (we) arch = v;
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        tick();
        alu_flag_we = 1'b0; err_clr = 1'b0;
    endtask

    task automatic end_check(input string tag);
        @(negedge clk);
        chk({tag, "_freg"}, 32'(freg), 32'(arch));
        chk({tag, "_depth"}, 32'(depth), 32'(stk.size()));
        chk({tag, "_ovf"}, 32'(ovf_err), 32'(m_ovf));
        chk({tag, "_unf"}, 32'(unf_err), 32'(m_unf));
        chk({tag, "_bk_hold"}, 32'(flags_bk), 32'(last_bk));
    endtask

    task automatic model_reset();
        stk.delete(); sb.delete();
        arch = 4'h0; last_bk = 4'h0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_acks", 32'({enter_ack, ret_ack}), 32'd0);
        chk("rst_ld_rest", 32'({flag_ld, flag_rest}), 32'd0);
        chk("rst_bk", 32'(flags_bk), 32'd0);
        chk("rst_errs", 32'({ovf_err, unf_err}), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Save 1010, ALU overwrites with 0101, return restores 1010
        idle_cycle(1'b1, 4'b1010, 1'b0);
        do_enter(1'b0, 4'h0, 1'b0);
        end_check("t1_enter");
        idle_cycle(1'b1, 4'b0101, 1'b0);
        end_check("t1_alu");
        do_ret(1'b0, 4'h0, 1'b0);
        end_check("t1_ret");

        // Nest to full, overflow, unwind, underflow
        for (int i = 1; i <= 4; i++) begin
            idle_cycle(1'b1, 4'(i), 1'b0);
            do_enter(1'b0, 4'h0, 1'b0);
        end
        end_check("t2_full");
        idle_cycle(1'b1, 4'hF, 1'b0);
        do_enter(1'b0, 4'h0, 1'b0);
        end_check("t3_ovf");
        for (int i = 0; i < 5; i++) begin
            do_ret(1'b0, 4'h0, 1'b0);
            end_check("t2_unwind");
        end
        idle_cycle(1'b0, 4'h0, 1'b1);
        end_check("t6_clr");

        // ALU write in the entry request cycle lands before the snapshot
        do_enter(1'b1, 4'hC, 1'b0);
        end_check("t4_enter");
        do_ret(1'b0, 4'h0, 1'b0);
        end_check("t4_ret");

        // Simultaneous requests at depth 1
        idle_cycle(1'b1, 4'h6, 1'b0);
        do_enter(1'b0, 4'h0, 1'b0);
        idle_cycle(1'b1, 4'h9, 1'b0);
        do_both();
        end_check("t5_both");

        // Error set beats a simultaneous clear
        do_ret(1'b0, 4'h0, 1'b0);
        do_ret(1'b0, 4'h0, 1'b1);
        end_check("t6_set_wins");

        // Reset during RESTORE aborts it
        idle_cycle(1'b1, 4'h3, 1'b0);
        do_enter(1'b0, 4'h0, 1'b0);
        ret_req = 1'b1;
        tick();
        rst = 1'b0;
        ret_req = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_ack", 32'(ret_ack), 32'd0);
        chk("t6_rst_rest", 32'(flag_rest), 32'd0);
        chk("t6_rst_depth", 32'(depth), 32'd0);
        chk("t6_rst_errs", 32'({ovf_err, unf_err}), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        end_check("t6_after_rst");

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    do_enter(1'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
                2, 3:    do_ret(1'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
                4:       if (stk.size() < DEPTH) do_both();
                         else idle_cycle(1'b1, 4'($urandom), 1'b0);
                default: idle_cycle(1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
            endcase
            end_check("rnd");
        end

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
